x_div_seq: RTL and testbench

- Iterative signed restoring divider. It is the inverse-direction companion to the processor's carry-lookahead adder datapath.
- Produces one quotient bit per clock using a WIDTH-bit subtract/compare stage.
- Sits in the multdiv unit beside the multiplier. It is driven by the execute stage with a start pulse and returns a one-cycle ready strobe.
- Division truncates toward zero, as in C / RISC-style integer divide.

---
 rtl/x_div_seq_if.sv | 55 +++++
 rtl/x_div_seq.sv | 149 ++++++++++++++
 tb/tb_x_div_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_div_seq_if.sv
// x_div_seq_if
//   Request/response bundle between the execute stage and the sequential
//   divider.
//
//   Handshake: the execute stage raises ctrl_div for one clock with
//   data_operandA/data_operandB valid in that same cycle; there is no ready
//   back-pressure, a start is always accepted and aborts any operation in
//   flight. The divider answers with data_resultRDY high for exactly one
//   cycle, and data_result/data_remainder/data_exception are valid in that
//   cycle and then hold until the next completion. busy is high while
//   quotient bits are being produced.
//
//   Signals:
//     ctrl_div        master->slave  start pulse
//     data_operandA   master->slave  dividend, two's complement
//     data_operandB   master->slave  divisor, two's complement
//     data_result     slave->master  signed quotient
//     data_remainder  slave->master  signed remainder (sign of dividend)
//     data_exception  slave->master  divide-by-zero flag
//     data_resultRDY  slave->master  one-cycle completion strobe
//     busy            slave->master  iteration sequence in progress
interface x_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_div,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_remainder,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_div,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_remainder,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/x_div_seq.sv
// x_div_seq
//   Iterative signed restoring divider, one quotient bit per clock.
//   Division truncates toward zero; the remainder takes the sign of the
//   dividend. A zero divisor completes the cycle after the start with
//   data_exception set, result 0 and remainder equal to the dividend.
//
//   Ports:
//     clock        system clock, rising edge
//     reset_n      asynchronous active-low reset
//     bus          x_div_seq_if slave modport (start, operands, results)
//     dbg_state_o  current FSM state (IDLE=0, RUN=1, DONE=2)
module x_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset_n,
    x_div_seq_if.slave     bus,
    output logic [1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;     // quotient sign
    logic             a_neg_q;    // dividend sign, gives the remainder sign
    logic [WIDTH-1:0] dvd_q;      // |A| shifting out the top, quotient in at the bottom
    logic [WIDTH-1:0] dvs_q;      // |B|
    // The partial remainder is always below |B| <= 2^(WIDTH-1), so its
    // (WIDTH+1)-bit form has a zero top bit; only WIDTH bits are stored and
    // the extra bit exists only inside the trial subtraction.
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remainder_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    // Operand magnitudes; negating the most negative value wraps to
    // 2^(WIDTH-1), which is the correct unsigned magnitude.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // One restoring iteration.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] remainder_d;

    always_comb begin
        abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
        abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        q_bit   = ~trial[WIDTH];
        rem_d   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d   = {dvd_q[WIDTH-2:0], q_bit};

        // Final sign correction, used only on the last iteration.
        result_d    = sign_q  ? (~quo_d + 1'b1) : quo_d;
        remainder_d = a_neg_q ? (~rem_d + 1'b1) : rem_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            a_neg_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (bus.ctrl_div) begin
                // A start wins in every state and silently drops any
                // operation in flight.
                sign_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                a_neg_q <= bus.data_operandA[WIDTH-1];
                dvd_q   <= abs_a;
                dvs_q   <= abs_b;
                rem_q   <= '0;
                cnt_q   <= '0;
                if (bus.data_operandB == '0) begin
                    state_q     <= DONE;
                    result_q    <= '0;
                    remainder_q <= bus.data_operandA;
                    exc_q       <= 1'b1;
                    rdy_q       <= 1'b1;
                    busy_q      <= 1'b0;
                end else begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    RUN: begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            state_q     <= DONE;
                            result_q    <= result_d;
                            remainder_q <= remainder_d;
                            exc_q       <= 1'b0;
                            rdy_q       <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = remainder_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_x_div_seq.sv
// tb_x_div_seq
//   Bench for x_div_seq: directed cases with literal expectations plus
//   randomized starts, restarts and operand scrambling, all checked every
//   cycle against an arithmetic model of the divider.
module tb_x_div_seq;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    x_div_seq_if #(.WIDTH(W)) bus ();
    logic [1:0] dbg_state;

    x_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // Literal results expected at the next completions of directed cases.
    logic [W-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // C-style truncating signed division in 64-bit arithmetic.
    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic e);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '0;
            r = a;
            e = 1'b1;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            e  = 1'b0;
        end
    endfunction

    // Pending operation: completes after `pend_left` further clock edges.
    bit           pend_v    = 1'b0;
    int           pend_left = 0;
    logic [W-1:0] pend_res, pend_rem;
    logic         pend_exc;
    logic [W-1:0] m_res = '0, m_rem = '0;
    logic         m_exc = 1'b0, m_rdy = 1'b0, m_busy = 1'b0;

    initial begin
        forever begin
            @(posedge clock);
            if (reset_n) begin
                m_rdy = 1'b0;
                if (bus.ctrl_div) begin
                    model_div(bus.data_operandA, bus.data_operandB, pend_res, pend_rem, pend_exc);
                    pend_v    = 1'b1;
                    pend_left = (bus.data_operandB == '0) ? 0 : W;
                end else if (pend_v) begin
                    pend_left--;
                end
                if (pend_v && pend_left == 0) begin
                    pend_v = 1'b0;
                    m_rdy  = 1'b1;
                    m_res  = pend_res;
                    m_rem  = pend_rem;
                    m_exc  = pend_exc;
                end
                m_busy = pend_v;
            end
        end
    end

    initial begin
        forever begin
            @(negedge reset_n);
            pend_v = 1'b0;
            m_res  = '0;
            m_rem  = '0;
            m_exc  = 1'b0;
            m_rdy  = 1'b0;
            m_busy = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [W-1:0] lit;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                chk("rdy",       W'(bus.data_resultRDY), W'(m_rdy));
                chk("busy",      W'(bus.busy),           W'(m_busy));
                chk("result",    bus.data_result,        m_res);
                chk("remainder", bus.data_remainder,     m_rem);
                if (m_rdy) chk("exception", W'(bus.data_exception), W'(m_exc));
                if (bus.data_resultRDY && exp_q.size() > 0) begin
                    lit = exp_q.pop_front();
                    chk("literal_result", bus.data_result, lit);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Directed divide: checks latency, remainder, exception and the
    // result (through exp_q) against literal values, then idle outputs.
    task automatic do_div(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_res, input logic [W-1:0] e_rem,
                          input logic e_exc, input int e_lat);
        int lat;
        exp_q.push_back(e_res);
        @(negedge clock);
        bus.ctrl_div      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_div      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        lat = 1;
        while (!bus.data_resultRDY && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, "_latency"},   W'(lat),                e_lat);
        chk({nm, "_remainder"}, bus.data_remainder,     e_rem);
        chk({nm, "_exception"}, W'(bus.data_exception), W'(e_exc));
        @(negedge clock);
        chk({nm, "_rdy_after"},  W'(bus.data_resultRDY), '0);
        chk({nm, "_busy_after"}, W'(bus.busy),           '0);
        chk({nm, "_hold"},       bus.data_result,        e_res);
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.ctrl_div      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_div      = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand(input bit divisor);
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return divisor ? 32'h0 : 32'hFFFF_FFFF;
            2:       return W'($urandom_range(0, 20));
            3:       return -W'($urandom_range(1, 20));
            4:       return divisor ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] q, r;
        logic         e;
        bus.ctrl_div      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        // Pin the model against hand-computed values.
        model_div(32'd100, 32'd7, q, r, e);
        chk("model_100_7_q", q, 32'd14);
        chk("model_100_7_r", r, 32'd2);
        model_div(-32'sd100, 32'd7, q, r, e);
        chk("model_m100_7_q", q, 32'hFFFF_FFF2);
        chk("model_m100_7_r", r, 32'hFFFF_FFFE);
        model_div(32'h8000_0000, 32'hFFFF_FFFF, q, r, e);
        chk("model_ovf_q", q, 32'h8000_0000);
        chk("model_ovf_r", r, 32'h0);
        model_div(32'h1234_5678, 32'h0, q, r, e);
        chk("model_dz", {r[W-1:1], e}, {32'h1234_5678 >> 1, 1'b1});

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rdy",  W'(bus.data_resultRDY), '0);
        chk("reset_busy", W'(bus.busy),           '0);
        chk("reset_exc",  W'(bus.data_exception), '0);
        chk("reset_res",  bus.data_result,        '0);
        chk("reset_rem",  bus.data_remainder,     '0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic signs.
        do_div("p100_p7",  32'd100,     32'd7,     32'd14,        32'd2,         1'b0, W + 1);
        do_div("m100_p7",  -32'sd100,   32'd7,     32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, W + 1);
        do_div("p100_m7",  32'd100,     -32'sd7,   32'hFFFF_FFF2, 32'd2,         1'b0, W + 1);
        do_div("m100_m7",  -32'sd100,   -32'sd7,   32'd14,        32'hFFFF_FFFE, 1'b0, W + 1);

        // Divide by zero, then a normal divide clears the exception.
        do_div("div_zero", 32'h1234_5678, 32'h0,   32'h0,         32'h1234_5678, 1'b1, 1);
        do_div("after_dz", 32'd9,       32'd3,     32'd3,         32'd0,         1'b0, W + 1);

        // Most negative dividend.
        do_div("ovf_m1",   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, W + 1);
        do_div("min_p1",   32'h8000_0000, 32'd1,   32'h8000_0000, 32'h0,         1'b0, W + 1);

        // Restart in flight: only the second operation completes.
        pulse_start(32'd50, 32'd5);
        repeat (8) @(negedge clock);
        do_div("restart",  32'd81,      32'd9,     32'd9,         32'd0,         1'b0, W + 1);

        // Asynchronous reset mid-operation, away from any clock edge.
        pulse_start(32'd50, 32'd5);
        repeat (19) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rdy",  W'(bus.data_resultRDY), '0);
        chk("arst_busy", W'(bus.busy),           '0);
        chk("arst_exc",  W'(bus.data_exception), '0);
        chk("arst_res",  bus.data_result,        '0);
        chk("arst_rem",  bus.data_remainder,     '0);
        repeat (3) @(negedge clock);
        chk("arst_hold_rdy", W'(bus.data_resultRDY), '0);
        reset_n = 1'b1;
        do_div("post_rst", 32'd7,       32'd2,     32'd3,         32'd1,         1'b0, W + 1);

        // Random starts, with operand scrambling and restarts at random
        // points (including during the completion cycle).
        for (int i = 0; i < 40; i++) begin
            int gap;
            pulse_start(rand_operand(1'b0), rand_operand(1'b1));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : W + 1;
            for (int k = 0; k < gap; k++) begin
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
                @(negedge clock);
            end
        end
        repeat (W + 5) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
